// File: rtl/mc_controller.sv
// mc_controller: multi-cycle control FSM for a MIPS subset, with a retired-instruction counter.
// Optional MC_CTRL_MEMWAIT_EN: IF and MEM stall until mem_rdy is high.
module mc_controller #(
   parameter int unsigned ALUOP_W = 3,
   parameter int unsigned CNT_W   = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         OpCode,
   input  logic [5:0]         func,
   input  logic               zero,
   input  logic               gtz,
   input  logic               mem_rdy,
   output logic               PCWrite,
   output logic               IRWrite,
   output logic               RegWrite,
   output logic               MemWrite,
   output logic               ALUSrc,
   output logic               Mem_to_Reg,
   output logic               J,
   output logic               jal,
   output logic               jr,
   output logic               illegal,
   output logic [1:0]         RegDst,
   output logic [1:0]         Extop,
   output logic [ALUOP_W-1:0] ALUop,
   output logic [1:0]         nPC_sel,
   output logic [2:0]         state,
   output logic [CNT_W-1:0]   instr_cnt
);

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EXE = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic       c_alu, c_lw, c_sw, c_beq, c_bgtz, c_j, c_jr, c_jal, c_ill;
   logic [2:0] alu_code;
   logic       mem_go;
   logic       pcw_c, irw_c, rw_c, mw_c, m2r_c, ill_c, j_c, jal_c, jr_c, done_c;

`ifdef MC_CTRL_MEMWAIT_EN
   assign mem_go = mem_rdy;
`else
   logic unused_mem_rdy;
   assign unused_mem_rdy = mem_rdy;
   assign mem_go         = 1'b1;
`endif

   // Instruction class and datapath controls, decoded straight from the IR fields
   always_comb begin
      c_alu    = 1'b0;
      c_lw     = 1'b0;
      c_sw     = 1'b0;
      c_beq    = 1'b0;
      c_bgtz   = 1'b0;
      c_j      = 1'b0;
      c_jr     = 1'b0;
      c_jal    = 1'b0;
      alu_code = 3'd0;
      RegDst   = 2'b00;
      Extop    = 2'b00;
      ALUSrc   = 1'b0;
      case (OpCode)
         6'b000000: begin
            case (func)
               6'b100001: begin c_alu = 1'b1; RegDst = 2'b01; end
               6'b100011: begin c_alu = 1'b1; RegDst = 2'b01; alu_code = 3'd1; end
               6'b101010: begin c_alu = 1'b1; RegDst = 2'b01; alu_code = 3'd3; end
               6'b001000: c_jr = 1'b1;
               default:   ;
            endcase
         end
         6'b001101: begin c_alu = 1'b1; ALUSrc = 1'b1; alu_code = 3'd2; end
         6'b100011: begin c_lw  = 1'b1; ALUSrc = 1'b1; Extop = 2'b01; end
         6'b101011: begin c_sw  = 1'b1; ALUSrc = 1'b1; Extop = 2'b01; end
         6'b000100: begin c_beq = 1'b1; Extop = 2'b01; alu_code = 3'd1; end
         6'b001111: begin c_alu = 1'b1; ALUSrc = 1'b1; Extop = 2'b10; alu_code = 3'd5; end
         6'b000010: c_j = 1'b1;
         6'b001000: begin c_alu = 1'b1; ALUSrc = 1'b1; Extop = 2'b01; alu_code = 3'd4; end
         6'b001001: begin c_alu = 1'b1; ALUSrc = 1'b1; Extop = 2'b01; end
         6'b000011: begin c_jal = 1'b1; RegDst = 2'b10; end
         6'b000111: begin c_bgtz = 1'b1; Extop = 2'b01; alu_code = 3'd6; end
         default:   ;
      endcase
      c_ill = ~(c_alu | c_lw | c_sw | c_beq | c_bgtz | c_j | c_jr | c_jal);
   end

   assign ALUop = ALUOP_W'(alu_code);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IF;
      else        state_q <= state_d;
   end

   // Next state and state-gated write enables; done_c marks the last cycle of a legal instruction
   always_comb begin
      state_d = state_q;
      pcw_c   = 1'b0;
      irw_c   = 1'b0;
      rw_c    = 1'b0;
      mw_c    = 1'b0;
      m2r_c   = 1'b0;
      ill_c   = 1'b0;
      j_c     = 1'b0;
      jal_c   = 1'b0;
      jr_c    = 1'b0;
      nPC_sel = 2'b00;
      done_c  = 1'b0;
      case (state_q)
         S_IF: begin
            irw_c = mem_go;
            pcw_c = mem_go;
            if (mem_go) state_d = S_ID;
         end
         S_ID: begin
            state_d = S_IF;
            if (c_j) begin
               pcw_c = 1'b1; nPC_sel = 2'b10; j_c = 1'b1; done_c = 1'b1;
            end else if (c_jr) begin
               pcw_c = 1'b1; nPC_sel = 2'b11; jr_c = 1'b1; done_c = 1'b1;
            end else if (c_jal) begin
               pcw_c = 1'b1; nPC_sel = 2'b10; rw_c = 1'b1; jal_c = 1'b1; done_c = 1'b1;
            end else if (c_ill) begin
               ill_c = 1'b1;
            end else begin
               state_d = S_EXE;
            end
         end
         S_EXE: begin
            if (c_alu) begin
               state_d = S_WB;
            end else if (c_lw || c_sw) begin
               state_d = S_MEM;
            end else begin
               if ((c_beq && zero) || (c_bgtz && gtz)) begin
                  pcw_c   = 1'b1;
                  nPC_sel = 2'b01;
               end
               done_c  = c_beq | c_bgtz;
               state_d = S_IF;
            end
         end
         S_MEM: begin
            mw_c = c_sw;
            if (mem_go) begin
               if (c_lw) begin
                  state_d = S_WB;
               end else begin
                  done_c  = c_sw;
                  state_d = S_IF;
               end
            end
         end
         S_WB: begin
            rw_c    = 1'b1;
            m2r_c   = c_lw;
            done_c  = 1'b1;
            state_d = S_IF;
         end
         default: state_d = S_IF;
      endcase
   end

   // Reset kills every write enable at once, even though IF is the reset state
   assign PCWrite    = pcw_c & rst_n;
   assign IRWrite    = irw_c & rst_n;
   assign RegWrite   = rw_c  & rst_n;
   assign MemWrite   = mw_c  & rst_n;
   assign Mem_to_Reg = m2r_c & rst_n;
   assign illegal    = ill_c & rst_n;
   assign J          = j_c   & rst_n;
   assign jal        = jal_c & rst_n;
   assign jr         = jr_c  & rst_n;
   assign state      = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      instr_cnt <= '0;
      else if (done_c) instr_cnt <= instr_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_mc_controller.sv
// Directed, table-driven bench for mc_controller, plus hand sequences for stalls, reset and wrap.
module tb_mc_controller;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [5:0]  op = 6'b000000;
   logic [5:0]  fn = 6'b100001;
   logic        zero = 1'b0;
   logic        gtz = 1'b0;
   logic        mem_rdy = 1'b1;

   logic        PCWrite, IRWrite, RegWrite, MemWrite, ALUSrc, Mem_to_Reg, J, jal, jr, illegal;
   logic [1:0]  RegDst, Extop, nPC_sel;
   logic [2:0]  ALUop;
   logic [2:0]  state;
   logic [31:0] instr_cnt;

   logic        s_unused_pcw, s_unused_irw, s_unused_rw, s_unused_mw, s_unused_src, s_unused_m2r;
   logic        s_unused_j, s_unused_jal, s_unused_jr, s_unused_ill;
   logic [1:0]  s_unused_rd, s_unused_ext, s_unused_npc;
   logic [2:0]  s_unused_alu, s_unused_st;
   logic [3:0]  cnt_s;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mc_controller dut (
      .clk(clk), .rst_n(rst_n), .OpCode(op), .func(fn), .zero(zero), .gtz(gtz), .mem_rdy(mem_rdy),
      .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
      .ALUSrc(ALUSrc), .Mem_to_Reg(Mem_to_Reg), .J(J), .jal(jal), .jr(jr), .illegal(illegal),
      .RegDst(RegDst), .Extop(Extop), .ALUop(ALUop), .nPC_sel(nPC_sel),
      .state(state), .instr_cnt(instr_cnt)
   );

   mc_controller #(.CNT_W(4)) u_small (
      .clk(clk), .rst_n(rst_n), .OpCode(op), .func(fn), .zero(zero), .gtz(gtz), .mem_rdy(mem_rdy),
      .PCWrite(s_unused_pcw), .IRWrite(s_unused_irw), .RegWrite(s_unused_rw),
      .MemWrite(s_unused_mw), .ALUSrc(s_unused_src), .Mem_to_Reg(s_unused_m2r),
      .J(s_unused_j), .jal(s_unused_jal), .jr(s_unused_jr), .illegal(s_unused_ill),
      .RegDst(s_unused_rd), .Extop(s_unused_ext), .ALUop(s_unused_alu), .nPC_sel(s_unused_npc),
      .state(s_unused_st), .instr_cnt(cnt_s)
   );

   // exp layout: {state[3], pcw,irw,rw,mw,m2r,ill, J,jal,jr, nPC_sel[2], RegDst[2], ALUop[3]}
   typedef struct {
      logic [5:0]  op;
      logic [5:0]  fn;
      logic        z;
      logic        g;
      logic [18:0] exp;
      int          cnt;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic [5:0] o, input logic [5:0] f, input logic z, input logic g,
                               input logic [2:0] st, input logic [5:0] we, input logic [2:0] jj,
                               input logic [1:0] npc, input logic [1:0] rd, input logic [2:0] alu,
                               input int cnt);
      vec_t v;
      v.op  = o;
      v.fn  = f;
      v.z   = z;
      v.g   = g;
      v.exp = {st, we, jj, npc, rd, alu};
      v.cnt = cnt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   logic [18:0] obs;

   initial begin
      // addu: IF ID EXE WB
      tbl.push_back(mk(6'o00, 6'b100001, 0, 0, 3'd0, 6'b110000, 3'b000, 2'b00, 2'b01, 3'd0, 0));
      tbl.push_back(mk(6'o00, 6'b100001, 0, 0, 3'd1, 6'b000000, 3'b000, 2'b00, 2'b01, 3'd0, 0));
      tbl.push_back(mk(6'o00, 6'b100001, 0, 0, 3'd2, 6'b000000, 3'b000, 2'b00, 2'b01, 3'd0, 0));
      tbl.push_back(mk(6'o00, 6'b100001, 0, 0, 3'd4, 6'b001000, 3'b000, 2'b00, 2'b01, 3'd0, 0));
      // lw: IF ID EXE MEM WB
      tbl.push_back(mk(6'b100011, 6'd0, 0, 0, 3'd0, 6'b110000, 3'b000, 2'b00, 2'b00, 3'd0, 1));
      tbl.push_back(mk(6'b100011, 6'd0, 0, 0, 3'd1, 6'b000000, 3'b000, 2'b00, 2'b00, 3'd0, 1));
      tbl.push_back(mk(6'b100011, 6'd0, 0, 0, 3'd2, 6'b000000, 3'b000, 2'b00, 2'b00, 3'd0, 1));
      tbl.push_back(mk(6'b100011, 6'd0, 0, 0, 3'd3, 6'b000000, 3'b000, 2'b00, 2'b00, 3'd0, 1));
      tbl.push_back(mk(6'b100011, 6'd0, 0, 0, 3'd4, 6'b001010, 3'b000, 2'b00, 2'b00, 3'd0, 1));
      // sw: IF ID EXE MEM
      tbl.push_back(mk(6'b101011, 6'd0, 0, 0, 3'd0, 6'b110000, 3'b000, 2'b00, 2'b00, 3'd0, 2));
      tbl.push_back(mk(6'b101011, 6'd0, 0, 0, 3'd1, 6'b000000, 3'b000, 2'b00, 2'b00, 3'd0, 2));
      tbl.push_back(mk(6'b101011, 6'd0, 0, 0, 3'd2, 6'b000000, 3'b000, 2'b00, 2'b00, 3'd0, 2));
      tbl.push_back(mk(6'b101011, 6'd0, 0, 0, 3'd3, 6'b000100, 3'b000, 2'b00, 2'b00, 3'd0, 2));
      // beq not taken, beq taken, bgtz taken
      tbl.push_back(mk(6'b000100, 6'd0, 0, 0, 3'd0, 6'b110000, 3'b000, 2'b00, 2'b00, 3'd1, 3));
      tbl.push_back(mk(6'b000100, 6'd0, 0, 0, 3'd1, 6'b000000, 3'b000, 2'b00, 2'b00, 3'd1, 3));
      tbl.push_back(mk(6'b000100, 6'd0, 0, 0, 3'd2, 6'b000000, 3'b000, 2'b00, 2'b00, 3'd1, 3));
      tbl.push_back(mk(6'b000100, 6'd0, 1, 0, 3'd0, 6'b110000, 3'b000, 2'b00, 2'b00, 3'd1, 4));
      tbl.push_back(mk(6'b000100, 6'd0, 1, 0, 3'd1, 6'b000000, 3'b000, 2'b00, 2'b00, 3'd1, 4));
      tbl.push_back(mk(6'b000100, 6'd0, 1, 0, 3'd2, 6'b100000, 3'b000, 2'b01, 2'b00, 3'd1, 4));
      tbl.push_back(mk(6'b000111, 6'd0, 0, 1, 3'd0, 6'b110000, 3'b000, 2'b00, 2'b00, 3'd6, 5));
      tbl.push_back(mk(6'b000111, 6'd0, 0, 1, 3'd1, 6'b000000, 3'b000, 2'b00, 2'b00, 3'd6, 5));
      tbl.push_back(mk(6'b000111, 6'd0, 0, 1, 3'd2, 6'b100000, 3'b000, 2'b01, 2'b00, 3'd6, 5));
      // jal, j, jr: IF ID
      tbl.push_back(mk(6'b000011, 6'd0, 0, 0, 3'd0, 6'b110000, 3'b000, 2'b00, 2'b10, 3'd0, 6));
      tbl.push_back(mk(6'b000011, 6'd0, 0, 0, 3'd1, 6'b101000, 3'b010, 2'b10, 2'b10, 3'd0, 6));
      tbl.push_back(mk(6'b000010, 6'd0, 0, 0, 3'd0, 6'b110000, 3'b000, 2'b00, 2'b00, 3'd0, 7));
      tbl.push_back(mk(6'b000010, 6'd0, 0, 0, 3'd1, 6'b100000, 3'b100, 2'b10, 2'b00, 3'd0, 7));
      tbl.push_back(mk(6'o00, 6'b001000, 0, 0, 3'd0, 6'b110000, 3'b000, 2'b00, 2'b00, 3'd0, 8));
      tbl.push_back(mk(6'o00, 6'b001000, 0, 0, 3'd1, 6'b100000, 3'b001, 2'b11, 2'b00, 3'd0, 8));
      // illegal opcode: IF ID, not counted
      tbl.push_back(mk(6'b111111, 6'd0, 0, 0, 3'd0, 6'b110000, 3'b000, 2'b00, 2'b00, 3'd0, 9));
      tbl.push_back(mk(6'b111111, 6'd0, 0, 0, 3'd1, 6'b000001, 3'b000, 2'b00, 2'b00, 3'd0, 9));
      // addi, lui: IF ID EXE WB
      tbl.push_back(mk(6'b001000, 6'd0, 0, 0, 3'd0, 6'b110000, 3'b000, 2'b00, 2'b00, 3'd4, 9));
      tbl.push_back(mk(6'b001000, 6'd0, 0, 0, 3'd1, 6'b000000, 3'b000, 2'b00, 2'b00, 3'd4, 9));
      tbl.push_back(mk(6'b001000, 6'd0, 0, 0, 3'd2, 6'b000000, 3'b000, 2'b00, 2'b00, 3'd4, 9));
      tbl.push_back(mk(6'b001000, 6'd0, 0, 0, 3'd4, 6'b001000, 3'b000, 2'b00, 2'b00, 3'd4, 9));
      tbl.push_back(mk(6'b001111, 6'd0, 0, 0, 3'd0, 6'b110000, 3'b000, 2'b00, 2'b00, 3'd5, 10));
      tbl.push_back(mk(6'b001111, 6'd0, 0, 0, 3'd1, 6'b000000, 3'b000, 2'b00, 2'b00, 3'd5, 10));
      tbl.push_back(mk(6'b001111, 6'd0, 0, 0, 3'd2, 6'b000000, 3'b000, 2'b00, 2'b00, 3'd5, 10));
      tbl.push_back(mk(6'b001111, 6'd0, 0, 0, 3'd4, 6'b001000, 3'b000, 2'b00, 2'b00, 3'd5, 10));

      // Reset state
      @(negedge clk);
      #1;
      chk("reset_outs", {state, PCWrite, IRWrite, RegWrite, MemWrite, illegal}, 8'd0);
      chk("reset_cnt", instr_cnt, 0);
      chk("reset_cnt_small", cnt_s, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table run: drive, settle, compare, advance one cycle
      foreach (tbl[i]) begin
         op   = tbl[i].op;
         fn   = tbl[i].fn;
         zero = tbl[i].z;
         gtz  = tbl[i].g;
         #1;
         obs = {state, PCWrite, IRWrite, RegWrite, MemWrite, Mem_to_Reg, illegal,
                J, jal, jr, nPC_sel, RegDst, ALUop};
         chk($sformatf("vec%0d_outs", i), obs, tbl[i].exp);
         chk($sformatf("vec%0d_cnt", i), instr_cnt, tbl[i].cnt);
         @(negedge clk);
      end

      // lw with mem_rdy low for two MEM cycles
      op = 6'b100011; fn = 6'd0; zero = 1'b0; gtz = 1'b0; mem_rdy = 1'b1;
`ifdef MC_CTRL_MEMWAIT_EN
      mem_rdy = 1'b0;
      #1;
      chk("if_wait_irw", {IRWrite, PCWrite}, 2'b00);
      @(negedge clk);
      #1;
      chk("if_wait_state", state, 3'd0);
      mem_rdy = 1'b1;
`endif
      #1;
      chk("lw_if", {state, IRWrite, PCWrite}, {3'd0, 2'b11});
      chk("lw_if_cnt", instr_cnt, 11);
      @(negedge clk); #1; chk("lw_id", state, 3'd1);
      @(negedge clk); #1; chk("lw_exe", state, 3'd2);
      @(negedge clk); mem_rdy = 1'b0; #1;
      chk("lw_mem0", {state, MemWrite, RegWrite}, {3'd3, 2'b00});
`ifdef MC_CTRL_MEMWAIT_EN
      @(negedge clk); #1; chk("lw_mem1", state, 3'd3);
      @(negedge clk); mem_rdy = 1'b1; #1; chk("lw_mem2", state, 3'd3);
`endif
      @(negedge clk); mem_rdy = 1'b1; #1;
      chk("lw_wb", {state, Mem_to_Reg, RegWrite}, {3'd4, 2'b11});
      @(negedge clk); #1;
      chk("lw_done_state", state, 3'd0);
      chk("lw_done_cnt", instr_cnt, 12);

      // sw aborted by reset during MEM
      op = 6'b101011;
      @(negedge clk); #1; chk("sw_id", state, 3'd1);
      @(negedge clk); #1; chk("sw_exe", state, 3'd2);
      @(negedge clk); #1; chk("sw_mem", {state, MemWrite}, {3'd3, 1'b1});
      #1 rst_n = 1'b0;
      #1;
      chk("sw_rst_memw", MemWrite, 1'b0);
      chk("sw_rst_state", state, 3'd0);
      chk("sw_rst_cnt", instr_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_if", {state, IRWrite}, {3'd0, 1'b1});

      // 4-bit counter wraps after 16 jumps
      op = 6'b000010;
      repeat (15) begin
         @(negedge clk);
         @(negedge clk);
      end
      #1;
      chk("wrap_pre_small", cnt_s, 4'd15);
      chk("wrap_pre_cnt", instr_cnt, 15);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("wrap_small", cnt_s, 4'd0);
      chk("wrap_cnt", instr_cnt, 16);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
